// File: rtl/nx_fifo_ctrl.sv
// FIFO pointer/occupancy controller: tracks head, tail and entry count for a
// parent-owned storage array of DEPTH slots (DEPTH need not be a power of two).
module nx_fifo_ctrl #(
    parameter int DEPTH            = 16,
    parameter int OVERFLOW_ASSERT  = 1,
    parameter int UNDERFLOW_ASSERT = 1,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wen,
    input  logic          ren,
    input  logic          clear,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] used_slots,
    output logic [CW-1:0] free_slots,
    output logic [PW-1:0] rptr,
    output logic [PW-1:0] wptr,
    output logic          underflow,
    output logic          overflow
);

    logic [CW-1:0] count;
    logic          wr_ok;
    logic          rd_ok;

    // Wrap at DEPTH-1 explicitly so non-power-of-two depths stay in range.
    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign used_slots = count;
    assign free_slots = CW'(DEPTH) - count;

    assign overflow   = wen & full;
    assign underflow  = ren & empty;
    assign wr_ok      = wen & ~full;
    assign rd_ok      = ren & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (clear) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) wptr <= inc_ptr(wptr);
            if (rd_ok) rptr <= inc_ptr(rptr);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Simulation-only diagnostics; they observe but never steer the datapath.
    if (OVERFLOW_ASSERT != 0) begin : g_ovf_chk
        always @(posedge clk) begin
            if (rst_n) assert (!overflow) else $error("nx_fifo_ctrl: write while full");
        end
    end

    if (UNDERFLOW_ASSERT != 0) begin : g_unf_chk
        always @(posedge clk) begin
            if (rst_n) assert (!underflow) else $error("nx_fifo_ctrl: read while empty");
        end
    end

endmodule

// File: tb/tb_nx_fifo_ctrl.sv
// Directed bench for nx_fifo_ctrl: a DEPTH=16 instance and a DEPTH=5 instance
// driven on the falling edge, checked with immediate assertions.
module tb_nx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wen, ren, clear;
    logic       empty, full, underflow, overflow;
    logic [4:0] used_slots, free_slots;
    logic [3:0] rptr, wptr;

    logic       w5, r5, c5;
    logic       empty5, full5, underflow5, overflow5;
    logic [2:0] used5, free5;
    logic [2:0] rptr5, wptr5;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nx_fifo_ctrl #(.DEPTH(16), .OVERFLOW_ASSERT(0), .UNDERFLOW_ASSERT(0)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .clear(clear),
        .empty(empty), .full(full), .used_slots(used_slots), .free_slots(free_slots),
        .rptr(rptr), .wptr(wptr), .underflow(underflow), .overflow(overflow)
    );

    nx_fifo_ctrl #(.DEPTH(5), .OVERFLOW_ASSERT(0), .UNDERFLOW_ASSERT(0)) dut5 (
        .clk(clk), .rst_n(rst_n), .wen(w5), .ren(r5), .clear(c5),
        .empty(empty5), .full(full5), .used_slots(used5), .free_slots(free5),
        .rptr(rptr5), .wptr(wptr5), .underflow(underflow5), .overflow(overflow5)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic c);
        wen   = w;
        ren   = r;
        clear = c;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0);
        w5 = 0; r5 = 0; c5 = 0;
        repeat (2) @(negedge clk);

        // Reset values while rst_n is held low
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_used", 32'(used_slots), 0);
        check("rst_free", 32'(free_slots), 16);
        check("rst_rptr", 32'(rptr), 0);
        check("rst_wptr", 32'(wptr), 0);
        check("rst_free5", 32'(free5), 5);
        rst_n = 1'b1;

        // Fill with 16 single writes
        for (int i = 1; i <= 16; i++) begin
            drive(1, 0, 0);
            @(negedge clk);
            check("fill_used", 32'(used_slots), 32'(i));
        end
        drive(0, 0, 0);
        #1;
        check("fill_full", 32'(full), 1);
        check("fill_free", 32'(free_slots), 0);
        check("fill_wptr", 32'(wptr), 0);
        check("fill_rptr", 32'(rptr), 0);

        // Write while full: rejected
        @(negedge clk);
        drive(1, 0, 0);
        #1;
        check("ovf_flag", 32'(overflow), 1);
        @(negedge clk);
        check("ovf_wptr", 32'(wptr), 0);
        check("ovf_used", 32'(used_slots), 16);

        // Write+read while full: write dropped, read proceeds
        drive(1, 1, 0);
        #1;
        check("ovf_rw_flag", 32'(overflow), 1);
        check("ovf_rw_unf", 32'(underflow), 0);
        @(negedge clk);
        check("ovf_rw_rptr", 32'(rptr), 1);
        check("ovf_rw_wptr", 32'(wptr), 0);
        check("ovf_rw_used", 32'(used_slots), 15);

        // Drain the remaining 15 entries; rptr wraps 15 -> 0
        drive(0, 1, 0);
        repeat (15) @(negedge clk);
        check("drain_empty", 32'(empty), 1);
        check("drain_rptr", 32'(rptr), 0);

        // Read while empty: rejected
        drive(0, 1, 0);
        #1;
        check("unf_flag", 32'(underflow), 1);
        @(negedge clk);
        check("unf_rptr", 32'(rptr), 0);
        check("unf_used", 32'(used_slots), 0);

        // Read+write while empty: read dropped, write proceeds
        drive(1, 1, 0);
        #1;
        check("unf_rw_flag", 32'(underflow), 1);
        check("unf_rw_ovf", 32'(overflow), 0);
        @(negedge clk);
        check("unf_rw_used", 32'(used_slots), 1);
        check("unf_rw_wptr", 32'(wptr), 1);
        check("unf_rw_rptr", 32'(rptr), 0);

        // Bring count to 7, then clear with a concurrent write
        drive(1, 0, 0);
        repeat (6) @(negedge clk);
        check("pre_clr_used", 32'(used_slots), 7);
        check("pre_clr_wptr", 32'(wptr), 7);
        drive(1, 0, 1);
        @(negedge clk);
        check("clr_rptr", 32'(rptr), 0);
        check("clr_wptr", 32'(wptr), 0);
        check("clr_used", 32'(used_slots), 0);
        check("clr_empty", 32'(empty), 1);

        // Flags still reflect pre-edge state while clear is high
        drive(0, 1, 1);
        #1;
        check("clr_unf_flag", 32'(underflow), 1);
        @(negedge clk);

        // Count to 9, then an asynchronous reset pulse between edges
        drive(1, 0, 0);
        repeat (9) @(negedge clk);
        drive(0, 0, 0);
        check("pre_rst_used", 32'(used_slots), 9);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_empty", 32'(empty), 1);
        check("arst_used", 32'(used_slots), 0);
        check("arst_wptr", 32'(wptr), 0);
        rst_n = 1'b1;
        drive(1, 0, 0);
        @(negedge clk);
        check("post_rst_used", 32'(used_slots), 1);
        check("post_rst_wptr", 32'(wptr), 1);
        drive(0, 0, 0);

        // DEPTH=5: prime one entry, then 12 simultaneous write/read pairs
        w5 = 1; r5 = 0;
        @(negedge clk);
        check("d5_prime_wptr", 32'(wptr5), 1);
        for (int k = 1; k <= 12; k++) begin
            w5 = 1; r5 = 1;
            @(negedge clk);
            check("d5_rptr", 32'(rptr5), 32'(k % 5));
            check("d5_wptr", 32'(wptr5), 32'((k + 1) % 5));
            check("d5_used", 32'(used5), 1);
        end

        // DEPTH=5: top up to full
        w5 = 1; r5 = 0;
        repeat (4) @(negedge clk);
        w5 = 0;
        #1;
        check("d5_full", 32'(full5), 1);
        check("d5_used_max", 32'(used5), 5);
        check("d5_free", 32'(free5), 0);
        check("d5_wptr_wrap", 32'(wptr5), 2);
        w5 = 1;
        #1;
        check("d5_ovf", 32'(overflow5), 1);
        @(negedge clk);
        w5 = 0;
        check("d5_ovf_used", 32'(used5), 5);
        check("d5_ovf_wptr", 32'(wptr5), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nx_fifo_ctrl.md
NX_FIFO_CTRL -- requirements
Module: nx_fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 16: number of FIFO slots; the SHALL-supported range is DEPTH >= 2, and DEPTH need not be a power of two.
REQ-002 Parameter OVERFLOW_ASSERT, default 1: when nonzero, an overflow SHALL raise a simulation error message.
REQ-003 Parameter UNDERFLOW_ASSERT, default 1: when nonzero, an underflow SHALL raise a simulation error message.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 wen  input  1  write request (push).
REQ-007 ren  input  1  read request (pop).
REQ-008 clear  input  1  synchronous flush.
REQ-009 empty  output  1  FIFO holds zero entries.
REQ-010 full  output  1  FIFO holds DEPTH entries.
REQ-011 used_slots  output  clog2(DEPTH+1)  current entry count.
REQ-012 free_slots  output  clog2(DEPTH+1)  DEPTH minus used_slots.
REQ-013 rptr  output  clog2(DEPTH)  storage index of the oldest entry (head).
REQ-014 wptr  output  clog2(DEPTH)  storage index for the next write.
REQ-015 underflow  output  1  combinational; the current-cycle read is rejected.
REQ-016 overflow  output  1  combinational; the current-cycle write is rejected.

Function
REQ-017 State SHALL consist of registered rptr, wptr and an entry count; empty, full, used_slots and free_slots SHALL be combinational decodes of that registered state.
REQ-018 empty SHALL be high if and only if count==0; full SHALL be high if and only if count==DEPTH.
REQ-019 used_slots SHALL equal count; free_slots SHALL equal DEPTH-count; both SHALL be zero-extended to the full output width.
REQ-020 A write is accepted if and only if wen=1 and full=0 in that cycle; on the next edge wptr SHALL advance by one.
REQ-021 A read is accepted if and only if ren=1 and empty=0 in that cycle; on the next edge rptr SHALL advance by one.
REQ-022 Both pointers SHALL wrap from DEPTH-1 to 0 (modulo DEPTH, not modulo 2^width).
REQ-023 Count update per cycle:
- +1 on an accepted write only;
- -1 on an accepted read only;
- unchanged when both are accepted, or when neither is accepted.
REQ-024 Acceptance SHALL be judged on pre-edge state: wen with ren while full SHALL be an overflow (write dropped) while the read proceeds; ren with wen while empty SHALL be an underflow while the write proceeds.
REQ-025 overflow SHALL equal wen AND full; underflow SHALL equal ren AND empty; both SHALL be combinational and asserted in the same cycle as the request.
REQ-026 A rejected request SHALL leave its pointer and the count unchanged.
REQ-027 Assertion messages SHALL fire on overflow or underflow only when the respective parameter is nonzero; they SHALL have no effect on hardware behaviour.
REQ-028 clear=1 at an edge SHALL set rptr=0, wptr=0 and count=0, overriding any accepted wen or ren in that cycle.
REQ-029 While clear=1, overflow and underflow SHALL still reflect the pre-edge state per REQ-025.
REQ-030 The block SHALL hold no data storage; the parent module writes its memory at wptr when wen and not full, and reads at rptr.

Reset
REQ-031 While rst_n=0:
- rptr=0, wptr=0, count=0;
- hence empty=1, full=0, used_slots=0, free_slots=DEPTH.
REQ-032 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-033 After rst_n deasserts, the block SHALL accept operations on the first rising clk edge.

Verification
REQ-034 DEPTH=16: after reset, 16 single writes -> used_slots counts 1..16, full=1 after the 16th, free_slots=0, wptr=0 (wrapped).
REQ-035 Full FIFO, wen=1 and ren=0 -> overflow=1 in that cycle, wptr and count unchanged; then wen=1 and ren=1 -> overflow=1, rptr+1, count=15.
REQ-036 Empty FIFO, ren=1 -> underflow=1, rptr unchanged; ren=1 and wen=1 together -> underflow=1, count=1, wptr+1.
REQ-037 DEPTH=5: 12 write/read pairs -> rptr and wptr sequence 0,1,2,3,4,0,1... and never reach 5; used_slots never exceeds 5.
REQ-038 count=7, clear=1 with wen=1 -> next cycle rptr=0, wptr=0, used_slots=0, empty=1.
REQ-039 count=9, rst_n pulsed low between edges -> empty=1 and used_slots=0 immediately, with no clock edge required.
